census_stereo_match: RTL and testbench

Census-domain stereo matcher that consumes the left and right census code streams produced by the census transform stage. For every left pixel it computes the Hamming cost against MAX_DISP right-image candidates on the same row. A winner-take-all selection emits one disparity and its cost per input pixel. It sits between the two census transform instances and the disparity post-filter / display path.

---
 rtl/census_pkg.sv | 27 ++
 rtl/census_wta.sv | 36 +++
 rtl/census_stereo_match.sv | 118 +++++++++++
 tb/tb_census_stereo_match.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/census_pkg.sv
`default_nettype none
// ============================================================================
// Module      : census_pkg
// Description : Shared census widths and the Hamming popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package census_pkg;

    localparam int IMAGE_WIDTH = 320;
    localparam int CODE_W      = 16;
    localparam int MAX_DISP    = 16;
    localparam int DISP_W      = $clog2(MAX_DISP);
    localparam int COST_W      = $clog2(CODE_W + 1);
    localparam int COL_W       = $clog2(IMAGE_WIDTH);

    // Wide input so any code width up to 64 bits can share one helper.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/census_wta.sv
`default_nettype none
// ============================================================================
// Module      : census_wta
// Description : Combinational winner-take-all argmin over eligible costs,
//               smallest index wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module census_wta #(
    parameter int N      = 16,
    parameter int COST_W = 5,
    parameter int DISP_W = 4
) (
    input  logic [N*COST_W-1:0] costs,
    input  logic [N-1:0]        elig,
    output logic [DISP_W-1:0]   disp,
    output logic [COST_W-1:0]   cost
);

    logic w_found;

    // Strict less-than keeps the earlier (smaller) disparity on a tie.
    always_comb begin
        w_found = 1'b0;
        disp    = '0;
        cost    = '0;
        for (int d = 0; d < N; d++) begin
            if (elig[d] && (!w_found || (costs[d*COST_W +: COST_W] < cost))) begin
                w_found = 1'b1;
                disp    = DISP_W'(d);
                cost    = costs[d*COST_W +: COST_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/census_stereo_match.sv
`default_nettype none
// ============================================================================
// Module      : census_stereo_match
// Description : Two-stage census Hamming stereo matcher with WTA disparity.
// Revision    : 1.0 - initial release
// ============================================================================
module census_stereo_match #(
    parameter int IMAGE_WIDTH = census_pkg::IMAGE_WIDTH,
    parameter int MAX_DISP    = census_pkg::MAX_DISP,
    parameter int CODE_W      = census_pkg::CODE_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [CODE_W-1:0]                left_code,
    input  logic [CODE_W-1:0]                right_code,
    output logic                             disp_valid,
    output logic [$clog2(MAX_DISP)-1:0]      disp_out,
    output logic [$clog2(CODE_W+1)-1:0]      cost_out,
    output logic [$clog2(IMAGE_WIDTH)-1:0]   col_out
);
    import census_pkg::*;

    localparam int c_disp_w = $clog2(MAX_DISP);
    localparam int c_cost_w = $clog2(CODE_W + 1);
    localparam int c_col_w  = $clog2(IMAGE_WIDTH);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMAGE_WIDTH - 1);

    // Only MAX_DISP-1 history taps are ever read; d=0 uses the live input.
    logic [CODE_W-1:0]          r_hist [MAX_DISP-1];
    logic [CODE_W-1:0]          w_cand [MAX_DISP];
    logic [c_col_w-1:0]         r_col;
    logic [c_col_w-1:0]         r_col1;
    logic [MAX_DISP*c_cost_w-1:0] w_cost;
    logic [MAX_DISP*c_cost_w-1:0] r_cost;
    logic [MAX_DISP-1:0]        w_elig;
    logic [MAX_DISP-1:0]        r_elig;
    logic                       r_v1;
    logic [c_disp_w-1:0]        w_win_disp;
    logic [c_cost_w-1:0]        w_win_cost;

    assign w_cand[0] = right_code;

    for (genvar d = 1; d < MAX_DISP; d++) begin : g_cand
        assign w_cand[d] = r_hist[d-1];
    end

    // Masking d > col keeps last row's history out of the first columns.
    always_comb begin
        w_cost = '0;
        w_elig = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            w_cost[d*c_cost_w +: c_cost_w] =
                c_cost_w'(popcount(64'(left_code ^ w_cand[d])));
            w_elig[d] = (d <= int'(r_col));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_DISP - 1; k++) begin
                r_hist[k] <= '0;
            end
            r_col <= '0;
        end else if (in_valid) begin
            r_hist[0] <= right_code;
            for (int k = 1; k < MAX_DISP - 1; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
            r_col <= (r_col == c_col_last) ? '0 : r_col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_cost <= '0;
            r_elig <= '0;
            r_col1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_cost <= w_cost;
                r_elig <= w_elig;
                r_col1 <= r_col;
            end
        end
    end

    census_wta #(
        .N      (MAX_DISP),
        .COST_W (c_cost_w),
        .DISP_W (c_disp_w)
    ) u_wta (
        .costs (r_cost),
        .elig  (r_elig),
        .disp  (w_win_disp),
        .cost  (w_win_cost)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid <= 1'b0;
            disp_out   <= '0;
            cost_out   <= '0;
            col_out    <= '0;
        end else begin
            disp_valid <= r_v1;
            if (r_v1) begin
                disp_out <= w_win_disp;
                cost_out <= w_win_cost;
                col_out  <= r_col1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_census_stereo_match.sv
`default_nettype none
// ============================================================================
// Module      : tb_census_stereo_match
// Description : Directed self-checking bench for census_stereo_match.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_census_stereo_match;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] left_code = '0;
    logic [15:0] right_code = '0;
    logic        disp_valid;
    logic [3:0]  disp_out;
    logic [4:0]  cost_out;
    logic [8:0]  col_out;

    int checks = 0;
    int errors = 0;

    census_stereo_match dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .left_code  (left_code),
        .right_code (right_code),
        .disp_valid (disp_valid),
        .disp_out   (disp_out),
        .cost_out   (cost_out),
        .col_out    (col_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic v, input logic [15:0] l, input logic [15:0] rc);
        rst        = r;
        in_valid   = v;
        left_code  = l;
        right_code = rc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 16'hA5A5, 16'h5A5A);
        step(1'b1, 1'b1, 16'h1234, 16'h4321);
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset disp_valid got %b expected 0", disp_valid); end
        checks++; if (disp_out !== 4'd0) begin errors++; $display("FAIL reset disp_out got %0d expected 0", disp_out); end
        checks++; if (cost_out !== 5'd0) begin errors++; $display("FAIL reset cost_out got %0d expected 0", cost_out); end
        checks++; if (col_out !== 9'd0) begin errors++; $display("FAIL reset col_out got %0d expected 0", col_out); end
    endtask

    task automatic test_identical;
        logic [15:0] c;
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 320; k++) begin
            c = 16'($urandom);
            step(1'b0, 1'b1, c, c);
            if (k >= 1) begin
                checks++;
                if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd0, 5'd0, 9'(k-1)}) begin
                    errors++;
                    $display("FAIL identical col %0d got v=%b d=%0d c=%0d col=%0d expected v=1 d=0 c=0", k-1, disp_valid, disp_out, cost_out, col_out);
                end
            end
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        checks++;
        if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd0, 5'd0, 9'd319}) begin
            errors++;
            $display("FAIL identical last got v=%b d=%0d c=%0d col=%0d expected v=1 d=0 c=0 col=319", disp_valid, disp_out, cost_out, col_out);
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL identical drain disp_valid got %b expected 0", disp_valid); end
    endtask

    task automatic test_shift;
        logic [15:0] lc [48];
        step(1'b1, 1'b0, 16'h0, 16'h0);
        // Odd multiplier plus xor is a bijection, so every code is distinct.
        for (int x = 0; x < 48; x++) lc[x] = 16'(x * 16'h9E37) ^ 16'h5A5A;
        for (int x = 0; x < 40; x++) begin
            step(1'b0, 1'b1, lc[x], lc[x+5]);
            if (x >= 1) begin
                if (x - 1 >= 5) begin
                    checks++;
                    if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd5, 5'd0, 9'(x-1)}) begin
                        errors++;
                        $display("FAIL shift col %0d got v=%b d=%0d c=%0d col=%0d expected v=1 d=5 c=0", x-1, disp_valid, disp_out, cost_out, col_out);
                    end
                end else begin
                    checks++;
                    if (disp_valid !== 1'b1 || col_out !== 9'(x-1) || 9'(disp_out) > col_out) begin
                        errors++;
                        $display("FAIL shift_edge col %0d got v=%b d=%0d col=%0d expected v=1 d<=col", x-1, disp_valid, disp_out, col_out);
                    end
                end
            end
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_masking;
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 320; k++) step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        checks++;
        if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd0, 5'd0, 9'd319}) begin
            errors++;
            $display("FAIL mask_prev got v=%b d=%0d c=%0d col=%0d expected v=1 d=0 c=0 col=319", disp_valid, disp_out, cost_out, col_out);
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        checks++;
        if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd0, 5'd16, 9'd0}) begin
            errors++;
            $display("FAIL mask_col0 got v=%b d=%0d c=%0d col=%0d expected v=1 d=0 c=16 col=0", disp_valid, disp_out, cost_out, col_out);
        end
    endtask

    task automatic test_tie_break;
        logic [15:0] rc;
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 16'h0, 16'h0);
            if (k >= 1) begin
                checks++;
                if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd0, 5'd0, 9'(k-1)}) begin
                    errors++;
                    $display("FAIL tie_zero col %0d got d=%0d c=%0d expected d=0 c=0", k-1, disp_out, cost_out);
                end
            end
        end
        // At col 10: d2 sees 0007, d7 sees 0700 (both cost 3), rest FFFF;
        // d11..15 would see reset zeros (cost 0) but are masked.
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int x = 0; x <= 10; x++) begin
            rc = (x == 8) ? 16'h0007 : (x == 3) ? 16'h0700 : 16'hFFFF;
            step(1'b0, 1'b1, (x == 10) ? 16'h0000 : 16'hFFFF, rc);
        end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        checks++;
        if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd2, 5'd3, 9'd10}) begin
            errors++;
            $display("FAIL tie_pick got v=%b d=%0d c=%0d col=%0d expected v=1 d=2 c=3 col=10", disp_valid, disp_out, cost_out, col_out);
        end
    endtask

    task automatic test_gaps;
        logic        gv [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] gl [4] = '{16'h1234, 16'h1234, 16'h1234, 16'h0F0F};
        logic [15:0] gr [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0F0E};
        logic [3:0]  ed [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
        logic [4:0]  ec [4] = '{5'd0, 5'd0, 5'd0, 5'd1};
        int in_idx;
        int out_idx;
        in_idx  = 0;
        out_idx = 0;
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 8; k++) begin
            if (gv[k]) begin
                step(1'b0, 1'b1, gl[in_idx], gr[in_idx]);
                in_idx++;
            end else begin
                step(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
            end
            if (k >= 1) begin
                checks++;
                if (disp_valid !== gv[k-1]) begin
                    errors++;
                    $display("FAIL gap_valid cycle %0d got %b expected %b", k, disp_valid, gv[k-1]);
                end
                if (gv[k-1]) begin
                    checks++;
                    if ({disp_out, cost_out, col_out} !== {ed[out_idx], ec[out_idx], 9'(out_idx)}) begin
                        errors++;
                        $display("FAIL gap_result %0d got d=%0d c=%0d col=%0d expected d=%0d c=%0d col=%0d",
                                 out_idx, disp_out, cost_out, col_out, ed[out_idx], ec[out_idx], out_idx);
                    end
                    out_idx++;
                end else if (out_idx > 0) begin
                    checks++;
                    if ({disp_out, cost_out, col_out} !== {ed[out_idx-1], ec[out_idx-1], 9'(out_idx-1)}) begin
                        errors++;
                        $display("FAIL gap_hold cycle %0d got d=%0d c=%0d col=%0d expected held d=%0d c=%0d col=%0d",
                                 k, disp_out, cost_out, col_out, ed[out_idx-1], ec[out_idx-1], out_idx-1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] c;
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 100; k++) begin
            c = 16'($urandom);
            step(1'b0, 1'b1, c, 16'($urandom));
        end
        step(1'b1, 1'b1, 16'h1111, 16'h2222);
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rstmid flush got v=%b expected 0", disp_valid); end
        step(1'b0, 1'b1, 16'hABCD, 16'h0000);
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rstmid bubble got v=%b expected 0", disp_valid); end
        step(1'b0, 1'b0, 16'h0, 16'h0);
        checks++;
        if ({disp_valid, disp_out, cost_out, col_out} !== {1'b1, 4'd0, 5'd10, 9'd0}) begin
            errors++;
            $display("FAIL rstmid first got v=%b d=%0d c=%0d col=%0d expected v=1 d=0 c=10 col=0", disp_valid, disp_out, cost_out, col_out);
        end
    endtask

    initial begin
        test_reset;
        test_identical;
        test_shift;
        test_masking;
        test_tie_break;
        test_gaps;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
